// File: rtl/uart_tx_fifo_if.sv
// Host-side word handshake for uart_tx_fifo: producer drives data_in/tx_valid,
// the transmitter answers with tx_ready.
interface uart_tx_fifo_if #(
  parameter int MAX_DATA_WIDTH = 9
) ();
  logic [MAX_DATA_WIDTH-1:0] data_in;
  logic                      tx_valid;
  logic                      tx_ready;

  modport master (output data_in, output tx_valid, input tx_ready);
  modport slave  (input data_in, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO and per-frame configuration latched at pop.
// Define UART_TX_BREAK_EN to add the break_req port and BREAK state.
module uart_tx_fifo #(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int OVERSAMPLING   = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int DIV_WIDTH      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  uart_tx_fifo_if.slave                   host,
  output logic                            tx,
  input  logic [3:0]                      cfg_data_bits,
  input  logic                            cfg_parity_en,
  input  logic                            cfg_parity_type,
  input  logic                            cfg_stop2,
  input  logic [DIV_WIDTH-1:0]            cfg_baud_div,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                            break_req
`endif
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int OSW = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1;
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLING - 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [3:0]     MAX_BITS = 4'(MAX_DATA_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
    ,
    ST_BREAK  = 3'd5
`endif
  } state_t;

  function automatic logic [3:0] eff_bits(input logic [3:0] req);
    if (req < 4'd5) begin
      eff_bits = 4'd5;
    end else if (req > MAX_BITS) begin
      eff_bits = MAX_BITS;
    end else begin
      eff_bits = req;
    end
  endfunction

  function automatic logic [MAX_DATA_WIDTH-1:0] mask_data(input logic [MAX_DATA_WIDTH-1:0] d,
                                                          input logic [3:0] n);
    for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
      mask_data[i] = (i < int'(n)) ? d[i] : 1'b0;
    end
  endfunction

  function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] d, input logic odd);
    parity_bit = odd ? ~^d : ^d;
  endfunction

  logic [MAX_DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr_r;
  logic [AW-1:0]             rd_ptr_r;
  logic [CW-1:0]             count_r;
  logic                      push_s;
  logic                      pop_s;
  logic                      brk_s;
  logic                      fifo_nempty_s;
  logic [3:0]                head_bits_s;
  logic [MAX_DATA_WIDTH-1:0] head_masked_s;

  state_t                    state_r;
  logic                      tx_r;
  logic                      busy_r;
  logic [MAX_DATA_WIDTH-1:0] shift_r;
  logic [3:0]                nbits_r;
  logic [3:0]                bit_idx_r;
  logic                      par_en_r;
  logic                      par_r;
  logic                      stop2_r;
  logic                      stop_idx_r;
  logic [DIV_WIDTH-1:0]      baud_div_r;
  logic [DIV_WIDTH-1:0]      div_cnt_r;
  logic [OSW-1:0]            tick_cnt_r;
  logic                      tick_s;
  logic                      bit_end_s;
  logic                      last_stop_s;

  assign fifo_nempty_s  = (count_r != {CW{1'b0}});
  assign host.tx_ready  = (count_r != CNT_FULL) && !reset;
  assign push_s         = host.tx_valid && host.tx_ready;
  assign head_bits_s    = eff_bits(cfg_data_bits);
  assign head_masked_s  = mask_data(mem_r[rd_ptr_r], head_bits_s);
  assign tick_s         = (div_cnt_r == baud_div_r);
  assign bit_end_s      = tick_s && (tick_cnt_r == OS_LAST);
  assign last_stop_s    = !stop2_r || stop_idx_r;
  assign tx             = tx_r;
  assign busy           = busy_r;
  assign fifo_count     = count_r;

`ifdef UART_TX_BREAK_EN
  logic       brk_enter_s;
  logic       brk_mark_r;
  logic [4:0] brk_bits_r;
  logic [4:0] brk_next_s;
  logic [4:0] frame_bits_r;
  logic [4:0] frame_bits_s;

  assign brk_s        = break_req;
  assign brk_next_s   = brk_bits_r + 5'd1;
  assign frame_bits_s = 5'd1 + {1'b0, head_bits_s} + {4'b0000, cfg_parity_en}
                        + (cfg_stop2 ? 5'd2 : 5'd1);
  // Break wins over a pop wherever a pop could happen
  assign brk_enter_s  = !reset && brk_s &&
                        ((state_r == ST_IDLE) ||
                         ((state_r == ST_STOP) && bit_end_s && last_stop_s));
`else
  assign brk_s = 1'b0;
`endif

  // Pop decision: from IDLE, or on the final cycle of the last stop bit
  always_comb begin
    pop_s = 1'b0;
    if (reset || brk_s || !fifo_nempty_s) begin
      pop_s = 1'b0;
    end else if (state_r == ST_IDLE) begin
      pop_s = 1'b1;
    end else if (state_r == ST_STOP) begin
      pop_s = bit_end_s && last_stop_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  // FIFO storage; flushing is done through the pointers
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= host.data_in;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Frame sequencer: state, latched frame settings, bit timing, registered tx/busy
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      shift_r    <= {MAX_DATA_WIDTH{1'b0}};
      nbits_r    <= 4'd5;
      bit_idx_r  <= 4'd0;
      par_en_r   <= 1'b0;
      par_r      <= 1'b0;
      stop2_r    <= 1'b0;
      stop_idx_r <= 1'b0;
      baud_div_r <= {DIV_WIDTH{1'b0}};
      div_cnt_r  <= {DIV_WIDTH{1'b0}};
      tick_cnt_r <= {OSW{1'b0}};
`ifdef UART_TX_BREAK_EN
      brk_mark_r   <= 1'b0;
      brk_bits_r   <= 5'd0;
      frame_bits_r <= 5'd0;
`endif
    end else begin
      busy_r <= (state_r != ST_IDLE) || fifo_nempty_s;

      if (state_r == ST_IDLE) begin
        div_cnt_r  <= {DIV_WIDTH{1'b0}};
        tick_cnt_r <= {OSW{1'b0}};
      end else if (tick_s) begin
        div_cnt_r  <= {DIV_WIDTH{1'b0}};
        tick_cnt_r <= (tick_cnt_r == OS_LAST) ? {OSW{1'b0}} : tick_cnt_r + OSW'(1);
      end else begin
        div_cnt_r  <= div_cnt_r + DIV_WIDTH'(1);
      end

      // tx follows the state one cycle later, so every bit keeps its full length
      case (state_r)
        ST_IDLE: begin
          tx_r <= 1'b1;
        end
        ST_START: begin
          tx_r <= 1'b0;
          if (bit_end_s) begin
            state_r <= ST_DATA;
          end
        end
        ST_DATA: begin
          tx_r <= shift_r[0];
          if (bit_end_s) begin
            shift_r <= {1'b0, shift_r[MAX_DATA_WIDTH-1:1]};
            if (bit_idx_r == nbits_r - 4'd1) begin
              bit_idx_r <= 4'd0;
              state_r   <= par_en_r ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          tx_r <= par_r;
          if (bit_end_s) begin
            state_r <= ST_STOP;
          end
        end
        ST_STOP: begin
          tx_r <= 1'b1;
          if (bit_end_s) begin
            if (last_stop_s) begin
              state_r <= ST_IDLE;
            end else begin
              stop_idx_r <= 1'b1;
            end
          end
        end
`ifdef UART_TX_BREAK_EN
        ST_BREAK: begin
          tx_r <= brk_mark_r;
          if (brk_mark_r) begin
            if (bit_end_s) begin
              state_r <= ST_IDLE;
            end
          end else begin
            if (bit_end_s && (brk_bits_r != 5'h1f)) begin
              brk_bits_r <= brk_next_s;
            end
            if (!brk_s && ((bit_end_s && (brk_next_s >= frame_bits_r)) ||
                           (brk_bits_r >= frame_bits_r))) begin
              brk_mark_r <= 1'b1;
              div_cnt_r  <= {DIV_WIDTH{1'b0}};
              tick_cnt_r <= {OSW{1'b0}};
            end
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
          tx_r    <= 1'b1;
        end
      endcase

      if (pop_s) begin
        state_r    <= ST_START;
        shift_r    <= head_masked_s;
        nbits_r    <= head_bits_s;
        par_en_r   <= cfg_parity_en;
        par_r      <= parity_bit(head_masked_s, cfg_parity_type);
        stop2_r    <= cfg_stop2;
        baud_div_r <= cfg_baud_div;
        div_cnt_r  <= {DIV_WIDTH{1'b0}};
        tick_cnt_r <= {OSW{1'b0}};
        bit_idx_r  <= 4'd0;
        stop_idx_r <= 1'b0;
      end
`ifdef UART_TX_BREAK_EN
      if (brk_enter_s) begin
        state_r      <= ST_BREAK;
        brk_mark_r   <= 1'b0;
        brk_bits_r   <= 5'd0;
        frame_bits_r <= frame_bits_s;
        baud_div_r   <= cfg_baud_div;
        div_cnt_r    <= {DIV_WIDTH{1'b0}};
        tick_cnt_r   <= {OSW{1'b0}};
      end
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: pushes record expected frames, a monitor
// decodes the tx line bit by bit against a behavioural frame model.
module tb_uart_tx_fifo;
  localparam int MDW   = 9;
  localparam int OS    = 16;
  localparam int DEPTH = 4;
  localparam int DW    = 16;

  typedef struct {
    logic [MDW-1:0] d;
    int             nb;
    bit             pen;
    bit             odd;
    bit             s2;
    int             bt;
  } frame_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tx;
  logic          busy;
  logic [2:0]    fifo_count;
  logic [3:0]    cfg_data_bits = 4'd8;
  logic          cfg_parity_en = 1'b0;
  logic          cfg_parity_type = 1'b0;
  logic          cfg_stop2 = 1'b0;
  logic [DW-1:0] cfg_baud_div = 16'd0;
`ifdef UART_TX_BREAK_EN
  logic          break_req = 1'b0;
`endif

  uart_tx_fifo_if #(.MAX_DATA_WIDTH(MDW)) host ();

  uart_tx_fifo #(
    .MAX_DATA_WIDTH(MDW), .OVERSAMPLING(OS), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .host(host), .tx(tx),
    .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
    .cfg_parity_type(cfg_parity_type), .cfg_stop2(cfg_stop2),
    .cfg_baud_div(cfg_baud_div), .busy(busy), .fifo_count(fifo_count)
`ifdef UART_TX_BREAK_EN
    , .break_req(break_req)
`endif
  );

  always #5 clk = ~clk;

  int     cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     last_hs = 0;
  int     last_start = 0;
  bit     mon_busy = 1'b0;
  bit     flush_req = 1'b0;
  frame_t sb_q[$];
  int     gap_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: frame settings captured from the configuration at handshake
  function automatic frame_t snap(input logic [MDW-1:0] d);
    frame_t f;
    int req;
    req   = int'(cfg_data_bits);
    f.d   = d;
    f.nb  = (req < 5) ? 5 : ((req > MDW) ? MDW : req);
    f.pen = cfg_parity_en;
    f.odd = cfg_parity_type;
    f.s2  = cfg_stop2;
    f.bt  = (int'(cfg_baud_div) + 1) * OS;
    return f;
  endfunction

  function automatic bit exp_bit(input frame_t f, input int k);
    int ones;
    ones = 0;
    if (k == 0) return 1'b0;
    if (k <= f.nb) return f.d[k-1];
    if (f.pen && k == f.nb + 1) begin
      for (int i = 0; i < f.nb; i++) ones += int'(f.d[i]);
      return f.odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    end
    return 1'b1;
  endfunction

  task automatic check_frame(input frame_t f);
    int nbits;
    nbits = 1 + f.nb + (f.pen ? 1 : 0) + (f.s2 ? 2 : 1);
    for (int k = 0; k < nbits; k++) begin
      bit   e;
      logic got;
      bit   bad;
      e = exp_bit(f, k);
      got = e;
      bad = 1'b0;
      for (int c = 0; c < f.bt; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        if (flush_req) return;
        if (tx !== e) begin
          bad = 1'b1;
          got = tx;
        end
      end
      n_cmp++;
      if (bad) begin
        n_bad++;
        $display("FAIL frame_bit %0d (data 0x%0h): tx=%b, expected %b", k, f.d, got, e);
      end
    end
  endtask

  initial begin : monitor
    int idle;
    idle = 0;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && !flush_req) begin
        mon_busy = 1'b1;
        gap_q.push_back(idle);
        idle = 0;
        last_start = cyc;
        if (sb_q.size() == 0) begin
          int n;
          n = 0;
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame: tx=0 at cycle %0d, expected idle 1", cyc);
          while (tx === 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
          end
        end else begin
          check_frame(sb_q.pop_front());
        end
        mon_busy = 1'b0;
      end else begin
        idle++;
      end
    end
  end

  task automatic push(input logic [MDW-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    host.data_in  = d;
    host.tx_valid = 1'b1;
    while (host.tx_ready !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready_bound", int'(n < 4000), 1);
    if (n < 4000) begin
      sb_q.push_back(snap(d));
      last_hs = cyc;
      @(posedge clk);
    end
    #1 host.tx_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0 || sb_q.size() != 0 || mon_busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) $display("FAIL drain_%s: still busy after %0d cycles, expected idle", tag, n);
    chk("drain_bound", int'(n < 20000), 1);
  endtask

  task automatic wait_frame_start();
    int n;
    n = 0;
    while (!mon_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_start_bound", int'(n < 2000), 1);
  endtask

  initial begin : stim
    host.data_in  = 9'd0;
    host.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", int'(tx), 1);
    chk("reset_tx_ready", int'(host.tx_ready), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_fifo_count", int'(fifo_count), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_release", int'(host.tx_ready), 1);

    // 8N1, divider 0: A5 frame and handshake-to-start latency
    push(9'h0A5);
    drain("8n1");
    chk("start_latency_edges", last_start - (last_hs + 1), 2);
    chk("idle_busy", int'(busy), 0);

    // 7E2, divider 1: bit 7 and up of 0x1C1 must be dropped
    cfg_data_bits = 4'd7; cfg_parity_en = 1'b1; cfg_parity_type = 1'b0;
    cfg_stop2 = 1'b1; cfg_baud_div = 16'd1;
    push(9'h1C1);
    drain("7e2");

    // Five words with the FIFO filling up; frames back-to-back, order kept
    cfg_data_bits = 4'd8; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0; cfg_baud_div = 16'd0;
    gap_q.delete();
    for (int i = 0; i < 4; i++) push(9'($urandom));
    @(negedge clk);
    chk("count_after_4", int'(fifo_count), 3);
    chk("ready_after_4", int'(host.tx_ready), 1);
    push(9'($urandom));
    @(negedge clk);
    chk("count_after_5", int'(fifo_count), 4);
    chk("ready_when_full", int'(host.tx_ready), 0);
    chk("busy_in_frame", int'(busy), 1);
    drain("b2b");
    chk("b2b_frames", gap_q.size(), 5);
    for (int i = 1; i < gap_q.size(); i++) chk("b2b_gap", gap_q[i], 0);

    // 8O1 0x00: parity type flipped mid-frame must not affect this frame
    cfg_parity_en = 1'b1; cfg_parity_type = 1'b1;
    push(9'h000);
    wait_frame_start();
    @(negedge clk);
    cfg_parity_type = 1'b0;
    drain("par_mid");
    push(9'h000);
    drain("par_next");

    // Reset in the middle of a data bit with three words still queued
    cfg_parity_en = 1'b0;
    for (int i = 0; i < 4; i++) push(9'($urandom));
    wait_frame_start();
    repeat (30) @(negedge clk);
    chk("count_before_reset", int'(fifo_count), 3);
    flush_req = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_tx", int'(tx), 1);
    chk("midreset_fifo_count", int'(fifo_count), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_tx_ready", int'(host.tx_ready), 0);
    reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("midreset_ready_release", int'(host.tx_ready), 1);
    @(negedge clk);
    flush_req = 1'b0;
    repeat (300) @(negedge clk);
    chk("post_reset_busy", int'(busy), 0);
    chk("post_reset_count", int'(fifo_count), 0);

    // Randomized batches; configuration only changes once everything is out
    for (int b = 0; b < 8; b++) begin
      int nw;
      cfg_data_bits   = 4'($urandom_range(3, 12));
      cfg_parity_en   = 1'($urandom_range(0, 1));
      cfg_parity_type = 1'($urandom_range(0, 1));
      cfg_stop2       = 1'($urandom_range(0, 1));
      cfg_baud_div    = 16'($urandom_range(0, 2));
      nw = int'($urandom_range(1, 3));
      for (int w = 0; w < nw; w++) begin
        push(9'($urandom));
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      drain("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
